ns_gnrl_pkt_arb_mux: RTL and testbench
======================================

// Module: ns_gnrl_pkt_arb_mux
// PURPOSE
//  N:1 packet-level arbitrating multiplexer. Shares one valid/ready output stream between ARBT_NUM requesters.
//  Grants use round-robin priority and are held for a whole packet (until the accepted beat with last=1).
//  A registered output slice decouples timing. Sits in front of shared sinks (bus master port, shared FIFO, DMA channel).
// PARAMETERS
//  ARBT_NUM  8   number of requesters, >=2
//  DW        32  payload width per beat
//  IDXW      $clog2(ARBT_NUM)  derived; do not override
// PORTS
//  clk       in   1              clock, single domain
//  rst_n     in   1              asynchronous, active-low reset
//  port_en   in   ARBT_NUM       per-requester enable; 0 = excluded from new arbitration
//  s_valid   in   ARBT_NUM       per-requester beat valid
//  s_data    in   ARBT_NUM*DW    payload; requester i uses bits [i*DW +: DW]
//  s_last    in   ARBT_NUM       last beat of packet, per requester
//  s_ready   out  ARBT_NUM       per-requester ready; at most one bit set
//  m_valid   out  1              output beat valid (registered)
//  m_data    out  DW             output payload (registered)
//  m_last    out  1              output last (registered)
//  m_src     out  IDXW           index of requester that sourced m_data (registered)
//  m_ready   in   1              downstream ready
//  gnt_vec   out  ARBT_NUM       one-hot current grant; 0 when IDLE (registered)
//  busy      out  1              1 while in LOCK or m_valid=1
// BEHAVIOUR
//  Reset: all outputs 0 (s_ready=0, m_valid=0, m_data=0, m_last=0, m_src=0, gnt_vec=0, busy=0).
//    state=IDLE; rr_ptr=ARBT_NUM-1, so requester 0 has top priority after reset.
//  FSM IDLE/LOCK.
//  IDLE:
//    - cand = s_valid & port_en.
//    - If cand!=0, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo ARBT_NUM.
//    - At the clock edge: gnt_idx<=winner, gnt_vec<=onehot(winner), rr_ptr<=winner, ->LOCK.
//    - s_ready=0 in IDLE; grant-to-first-beat latency is 1 cycle.
//  LOCK:
//    - slot_free = !m_valid | m_ready; s_ready[gnt_idx]=slot_free; all other s_ready bits 0.
//    - Beat accepted when s_valid[gnt_idx] & slot_free. At the edge: m_valid<=1, m_data/m_last<=selected inputs, m_src<=gnt_idx.
//    - If the accepted beat has s_last=1: ->IDLE and gnt_vec<=0. One bubble cycle before the next grant.
//    - s_valid[gnt_idx]=0 mid-packet: stay in LOCK, no timeout.
//    - port_en and other requesters are ignored in LOCK. Deasserting port_en[gnt_idx] mid-packet does not abort the packet.
//  Output slice:
//    - If m_valid & m_ready and no new beat is loaded: m_valid<=0.
//    - If m_valid & !m_ready: m_data/m_last/m_src hold stable, and s_ready=0.
//    - Full throughput: a sustained 1 beat/cycle stream is possible while m_ready=1.
//  Input-to-output latency: 1 cycle (accepted at edge k, visible after edge k).
//  busy = (state==LOCK) | m_valid.
//  Reset asserted mid-packet: everything clears asynchronously. The in-flight beat and the partial packet are dropped.
//    No resume; the requester must restart its packet.
//  Fairness: a requester continuously valid and enabled is granted within ARBT_NUM-1 packets of other requesters.
// STRUCTURE
//  Package ns_gnrl_arb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e; onehot/index conversion functions.
//  Sub-module ns_gnrl_rr_pick #(ARBT_NUM):
//    - combinational rotating-priority picker
//    - in: cand, rr_ptr; out: found, win_idx, win_onehot
//    - implemented via double-width masked priority encode.
//  Top holds the FSM, rr_ptr, the gnt_idx register, the input select mux and the output slice.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, s_valid=8'h01 single-beat -> m_src=0 two edges later.
//  2 Round-robin: s_valid=8'h81, all single-beat, m_ready=1, port_en=8'hFF -> m_src sequence 0,7,0,7; one bubble per packet.
//  3 Packet lock:
//    - requester 2 sends a 4-beat packet (data 0xA0..0xA3); requester 5 raises valid at beat 2.
//    - expect m_src=2 for all 4 beats, then requester 5's packet. No interleave; s_ready[5]=0 throughout.
//  4 Backpressure:
//    - m_ready=0 for 5 cycles mid-packet -> m_data stable, s_ready=0, no beat lost or duplicated.
//    - on release, the beat order is preserved.
//  5 Mask:
//    - port_en=8'hFB with only s_valid[2]=1 -> no grant, busy=0.
//    - set port_en=8'hFF -> gnt_vec=8'h04 next edge.
//    - clear port_en[2] mid-packet -> the packet completes.
//  6 Reset mid-packet: assert rst_n=0 during beat 2 of 4 -> outputs 0 immediately. After release, with all valid, requester 0 wins first.

Source files
------------

// File: rtl/ns_gnrl_pkt_arb_mux_pkg.sv
// Shared types and small index helpers for the packet arbitrating mux.
package ns_gnrl_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // One bit of a one-hot encoding: true when bit position pos is the one selected by idx.
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
    return (idx == pos);
  endfunction

  // Folds a position in a double-width search vector back onto a requester index.
  function automatic int unsigned wrap_idx(input int unsigned pos, input int unsigned n);
    return (pos >= n) ? (pos - n) : pos;
  endfunction

endpackage

// File: rtl/ns_gnrl_pkt_arb_mux_if.sv
// Requester-side and downstream-side bundle of the packet arbitrating mux.
interface ns_gnrl_pkt_arb_mux_if #(
  parameter int ARBT_NUM = 8,
  parameter int DW       = 32
);
  localparam int IDXW = $clog2(ARBT_NUM);

  logic [ARBT_NUM-1:0]    port_en;
  logic [ARBT_NUM-1:0]    s_valid;
  logic [ARBT_NUM*DW-1:0] s_data;
  logic [ARBT_NUM-1:0]    s_last;
  logic [ARBT_NUM-1:0]    s_ready;
  logic                   m_valid;
  logic [DW-1:0]          m_data;
  logic                   m_last;
  logic [IDXW-1:0]        m_src;
  logic                   m_ready;
  logic [ARBT_NUM-1:0]    gnt_vec;
  logic                   busy;

  modport slave (
    input  port_en, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_src, gnt_vec, busy
  );

  modport master (
    output port_en, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_src, gnt_vec, busy
  );

endinterface

// File: rtl/ns_gnrl_pkt_arb_mux_rr_pick.sv
// Combinational rotating-priority picker: first candidate after rr_ptr, wrapping around.
module ns_gnrl_rr_pick
  import ns_gnrl_arb_pkg::*;
#(
  parameter  int ARBT_NUM = 8,
  localparam int IDXW     = $clog2(ARBT_NUM)
) (
  input  logic [ARBT_NUM-1:0] cand,
  input  logic [IDXW-1:0]     rr_ptr,
  output logic                found,
  output logic [IDXW-1:0]     win_idx,
  output logic [ARBT_NUM-1:0] win_onehot
);

  logic [2*ARBT_NUM-1:0] dbl;

  // Lower half keeps only candidates above rr_ptr; upper half is the full wrap-around copy.
  always_comb begin
    dbl = '0;
    for (int j = 0; j < ARBT_NUM; j++) begin
      dbl[j]            = cand[j] & (j > int'(rr_ptr));
      dbl[j + ARBT_NUM] = cand[j];
    end
  end

  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int j = 2*ARBT_NUM-1; j >= 0; j--) begin
      if (dbl[j]) begin
        found   = 1'b1;
        win_idx = IDXW'(wrap_idx(j, ARBT_NUM));
      end
    end
    for (int i = 0; i < ARBT_NUM; i++) begin
      win_onehot[i] = found & onehot_bit(32'(win_idx), i);
    end
  end

endmodule

// File: rtl/ns_gnrl_pkt_arb_mux.sv
// N:1 packet-level round-robin arbitrating mux with a registered output slice.
module ns_gnrl_pkt_arb_mux
  import ns_gnrl_arb_pkg::*;
#(
  parameter  int ARBT_NUM = 8,
  parameter  int DW       = 32,
  localparam int IDXW     = $clog2(ARBT_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ns_gnrl_pkt_arb_mux_if.slave   bus
);

  arb_state_e          state, state_nxt;
  logic [IDXW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IDXW-1:0]     gnt_idx, gnt_idx_nxt;
  logic [ARBT_NUM-1:0] gnt_vec_q, gnt_vec_nxt;
  logic [ARBT_NUM-1:0] cand, win_onehot, s_ready_c;
  logic                found;
  logic [IDXW-1:0]     win_idx;
  logic                slot_free, sel_valid, sel_last, accept;
  logic [DW-1:0]       sel_data;
  logic                m_valid_q, m_last_q;
  logic [DW-1:0]       m_data_q;
  logic [IDXW-1:0]     m_src_q;

  assign cand = bus.s_valid & bus.port_en;

  ns_gnrl_rr_pick #(.ARBT_NUM(ARBT_NUM)) u_pick (
    .cand       (cand),
    .rr_ptr     (rr_ptr),
    .found      (found),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  assign slot_free = !m_valid_q | bus.m_ready;
  assign sel_valid = bus.s_valid[gnt_idx];
  assign sel_last  = bus.s_last[gnt_idx];
  assign sel_data  = bus.s_data[gnt_idx*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      rr_ptr    <= IDXW'(ARBT_NUM-1);
      gnt_idx   <= '0;
      gnt_vec_q <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_vec_q <= gnt_vec_nxt;
    end
  end

  // The grant is held until the granted requester's last beat is accepted.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    gnt_idx_nxt = gnt_idx;
    gnt_vec_nxt = gnt_vec_q;
    accept      = 1'b0;
    s_ready_c   = '0;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_nxt   = ARB_LOCK;
          rr_ptr_nxt  = win_idx;
          gnt_idx_nxt = win_idx;
          gnt_vec_nxt = win_onehot;
        end
      end
      ARB_LOCK: begin
        for (int i = 0; i < ARBT_NUM; i++) begin
          s_ready_c[i] = slot_free & onehot_bit(32'(gnt_idx), i);
        end
        accept = sel_valid & slot_free;
        if (accept && sel_last) begin
          state_nxt   = ARB_IDLE;
          gnt_vec_nxt = '0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Output slice: loads on accept, drains when downstream takes the beat, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_src_q   <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= sel_data;
      m_last_q  <= sel_last;
      m_src_q   <= gnt_idx;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_src   = m_src_q;
  assign bus.gnt_vec = gnt_vec_q;
  assign bus.busy    = (state == ARB_LOCK) | m_valid_q;

endmodule

// File: tb/tb_ns_gnrl_pkt_arb_mux.sv
// Directed self-checking bench for ns_gnrl_pkt_arb_mux (8 requesters, 32-bit data).
module tb_ns_gnrl_pkt_arb_mux;

  localparam int N  = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  ns_gnrl_pkt_arb_mux_if #(.ARBT_NUM(N), .DW(DW)) bus_if ();

  ns_gnrl_pkt_arb_mux #(.ARBT_NUM(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] d);
    bus_if.s_data[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    bus_if.s_valid = '0;
    bus_if.s_last  = '0;
    bus_if.s_data  = '0;
    bus_if.port_en = '1;
    bus_if.m_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus_if.s_valid = 8'($urandom);
    bus_if.s_last  = 8'($urandom);
    bus_if.port_en = 8'($urandom);
    bus_if.m_ready = 1'($urandom);
    for (int i = 0; i < N; i++) set_lane(i, $urandom);
    repeat (2) @(posedge clk);
    #1;
    check_cnt++; if (bus_if.s_ready !== 8'h00) $display("[TB] FAIL rst_s_ready got %0h exp 00", bus_if.s_ready); else pass_cnt++;
    check_cnt++; if (bus_if.m_valid !== 1'b0) $display("[TB] FAIL rst_m_valid got %0b exp 0", bus_if.m_valid); else pass_cnt++;
    check_cnt++; if (bus_if.m_data !== 32'h0) $display("[TB] FAIL rst_m_data got %0h exp 0", bus_if.m_data); else pass_cnt++;
    check_cnt++; if (bus_if.m_last !== 1'b0) $display("[TB] FAIL rst_m_last got %0b exp 0", bus_if.m_last); else pass_cnt++;
    check_cnt++; if (bus_if.m_src !== 3'd0) $display("[TB] FAIL rst_m_src got %0d exp 0", bus_if.m_src); else pass_cnt++;
    check_cnt++; if (bus_if.gnt_vec !== 8'h00) $display("[TB] FAIL rst_gnt_vec got %0h exp 00", bus_if.gnt_vec); else pass_cnt++;
    check_cnt++; if (bus_if.busy !== 1'b0) $display("[TB] FAIL rst_busy got %0b exp 0", bus_if.busy); else pass_cnt++;

    bus_if.s_valid = 8'h01;
    bus_if.s_last  = 8'h01;
    bus_if.port_en = 8'hFF;
    bus_if.m_ready = 1'b1;
    set_lane(0, 32'h11);
    rst_n = 1'b1;
    tick();
    check_cnt++; if (bus_if.gnt_vec !== 8'h01) $display("[TB] FAIL first_gnt got %0h exp 01", bus_if.gnt_vec); else pass_cnt++;
    check_cnt++; if (bus_if.m_valid !== 1'b0) $display("[TB] FAIL first_lat_valid got %0b exp 0", bus_if.m_valid); else pass_cnt++;
    check_cnt++; if (bus_if.s_ready !== 8'h01) $display("[TB] FAIL first_s_ready got %0h exp 01", bus_if.s_ready); else pass_cnt++;
    tick();
    check_cnt++; if (bus_if.m_valid !== 1'b1) $display("[TB] FAIL first_m_valid got %0b exp 1", bus_if.m_valid); else pass_cnt++;
    check_cnt++; if (bus_if.m_src !== 3'd0) $display("[TB] FAIL first_m_src got %0d exp 0", bus_if.m_src); else pass_cnt++;
    check_cnt++; if (bus_if.m_data !== 32'h11) $display("[TB] FAIL first_m_data got %0h exp 11", bus_if.m_data); else pass_cnt++;
    bus_if.s_valid = 8'h00;
    tick();
    check_cnt++; if (bus_if.m_valid !== 1'b0) $display("[TB] FAIL first_drain got %0b exp 0", bus_if.m_valid); else pass_cnt++;
    check_cnt++; if (bus_if.busy !== 1'b0) $display("[TB] FAIL first_busy got %0b exp 0", bus_if.busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_src [4];
    logic [31:0] exp_data;
    exp_src = '{3'd0, 3'd7, 3'd0, 3'd7};
    apply_reset();
    bus_if.s_last = 8'hFF;
    set_lane(0, 32'h100);
    set_lane(7, 32'h700);
    bus_if.s_valid = 8'h81;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e % 2 == 0) begin
        exp_data = (exp_src[e/2-1] == 3'd0) ? 32'h100 : 32'h700;
        check_cnt++; if (bus_if.m_valid !== 1'b1) $display("[TB] FAIL rr_valid_e%0d got %0b exp 1", e, bus_if.m_valid); else pass_cnt++;
        check_cnt++; if (bus_if.m_src !== exp_src[e/2-1]) $display("[TB] FAIL rr_src_e%0d got %0d exp %0d", e, bus_if.m_src, exp_src[e/2-1]); else pass_cnt++;
        check_cnt++; if (bus_if.m_data !== exp_data) $display("[TB] FAIL rr_data_e%0d got %0h exp %0h", e, bus_if.m_data, exp_data); else pass_cnt++;
      end else begin
        check_cnt++; if (bus_if.m_valid !== 1'b0) $display("[TB] FAIL rr_bubble_e%0d got %0b exp 0", e, bus_if.m_valid); else pass_cnt++;
      end
    end
    bus_if.s_valid = 8'h00;
    tick();
  endtask

  task automatic test_packet_lock();
    apply_reset();
    bus_if.s_valid = 8'h04;
    set_lane(2, 32'hA0);
    set_lane(5, 32'h50);
    tick();
    check_cnt++; if (bus_if.gnt_vec !== 8'h04) $display("[TB] FAIL lock_gnt got %0h exp 04", bus_if.gnt_vec); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      set_lane(2, 32'hA0 + 32'(k));
      bus_if.s_last  = (k == 3) ? 8'h24 : 8'h20;
      bus_if.s_valid = (k >= 1) ? 8'h24 : 8'h04;
      #1;
      check_cnt++; if (bus_if.s_ready !== 8'h04) $display("[TB] FAIL lock_s_ready_b%0d got %0h exp 04", k, bus_if.s_ready); else pass_cnt++;
      tick();
      check_cnt++; if (bus_if.m_src !== 3'd2) $display("[TB] FAIL lock_src_b%0d got %0d exp 2", k, bus_if.m_src); else pass_cnt++;
      check_cnt++; if (bus_if.m_data !== 32'hA0 + 32'(k)) $display("[TB] FAIL lock_data_b%0d got %0h exp %0h", k, bus_if.m_data, 32'hA0 + 32'(k)); else pass_cnt++;
      check_cnt++; if (bus_if.m_last !== (k == 3)) $display("[TB] FAIL lock_last_b%0d got %0b exp %0b", k, bus_if.m_last, (k == 3)); else pass_cnt++;
    end
    bus_if.s_valid = 8'h20;
    tick();
    check_cnt++; if (bus_if.gnt_vec !== 8'h20) $display("[TB] FAIL lock_next_gnt got %0h exp 20", bus_if.gnt_vec); else pass_cnt++;
    check_cnt++; if (bus_if.m_valid !== 1'b0) $display("[TB] FAIL lock_bubble got %0b exp 0", bus_if.m_valid); else pass_cnt++;
    tick();
    check_cnt++; if (bus_if.m_src !== 3'd5) $display("[TB] FAIL lock_next_src got %0d exp 5", bus_if.m_src); else pass_cnt++;
    check_cnt++; if (bus_if.m_data !== 32'h50) $display("[TB] FAIL lock_next_data got %0h exp 50", bus_if.m_data); else pass_cnt++;
    bus_if.s_valid = 8'h00;
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus_if.s_valid = 8'h02;
    set_lane(1, 32'hB0);
    tick();
    tick();
    check_cnt++; if (bus_if.m_data !== 32'hB0) $display("[TB] FAIL bp_b0 got %0h exp B0", bus_if.m_data); else pass_cnt++;
    set_lane(1, 32'hB1);
    bus_if.m_ready = 1'b0;
    #1;
    check_cnt++; if (bus_if.s_ready !== 8'h00) $display("[TB] FAIL bp_s_ready got %0h exp 00", bus_if.s_ready); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_cnt++; if (bus_if.m_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid_c%0d got %0b exp 1", c, bus_if.m_valid); else pass_cnt++;
      check_cnt++; if (bus_if.m_data !== 32'hB0) $display("[TB] FAIL bp_hold_data_c%0d got %0h exp B0", c, bus_if.m_data); else pass_cnt++;
      check_cnt++; if (bus_if.s_ready !== 8'h00) $display("[TB] FAIL bp_hold_ready_c%0d got %0h exp 00", c, bus_if.s_ready); else pass_cnt++;
    end
    bus_if.m_ready = 1'b1;
    #1;
    check_cnt++; if (bus_if.s_ready !== 8'h02) $display("[TB] FAIL bp_release_ready got %0h exp 02", bus_if.s_ready); else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      set_lane(1, 32'hB0 + 32'(k));
      bus_if.s_last = (k == 3) ? 8'h02 : 8'h00;
      tick();
      check_cnt++; if (bus_if.m_data !== 32'hB0 + 32'(k)) $display("[TB] FAIL bp_order_b%0d got %0h exp %0h", k, bus_if.m_data, 32'hB0 + 32'(k)); else pass_cnt++;
    end
    check_cnt++; if (bus_if.m_last !== 1'b1) $display("[TB] FAIL bp_last got %0b exp 1", bus_if.m_last); else pass_cnt++;
    bus_if.s_valid = 8'h00;
    tick();
    check_cnt++; if (bus_if.m_valid !== 1'b0) $display("[TB] FAIL bp_drain got %0b exp 0", bus_if.m_valid); else pass_cnt++;
  endtask

  task automatic test_mask();
    apply_reset();
    bus_if.port_en = 8'hFB;
    bus_if.s_valid = 8'h04;
    set_lane(2, 32'hC0);
    tick();
    tick();
    check_cnt++; if (bus_if.gnt_vec !== 8'h00) $display("[TB] FAIL mask_gnt got %0h exp 00", bus_if.gnt_vec); else pass_cnt++;
    check_cnt++; if (bus_if.busy !== 1'b0) $display("[TB] FAIL mask_busy got %0b exp 0", bus_if.busy); else pass_cnt++;
    bus_if.port_en = 8'hFF;
    tick();
    check_cnt++; if (bus_if.gnt_vec !== 8'h04) $display("[TB] FAIL mask_en_gnt got %0h exp 04", bus_if.gnt_vec); else pass_cnt++;
    bus_if.port_en = 8'hFB;
    tick();
    check_cnt++; if (bus_if.m_data !== 32'hC0) $display("[TB] FAIL mask_b0 got %0h exp C0", bus_if.m_data); else pass_cnt++;
    set_lane(2, 32'hC1);
    bus_if.s_last = 8'h04;
    tick();
    check_cnt++; if (bus_if.m_data !== 32'hC1) $display("[TB] FAIL mask_b1 got %0h exp C1", bus_if.m_data); else pass_cnt++;
    check_cnt++; if (bus_if.m_last !== 1'b1) $display("[TB] FAIL mask_last got %0b exp 1", bus_if.m_last); else pass_cnt++;
    check_cnt++; if (bus_if.gnt_vec !== 8'h00) $display("[TB] FAIL mask_release got %0h exp 00", bus_if.gnt_vec); else pass_cnt++;
    check_cnt++; if (bus_if.busy !== 1'b1) $display("[TB] FAIL mask_busy_tail got %0b exp 1", bus_if.busy); else pass_cnt++;
    bus_if.s_valid = 8'h00;
    tick();
    check_cnt++; if (bus_if.busy !== 1'b0) $display("[TB] FAIL mask_idle_busy got %0b exp 0", bus_if.busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    bus_if.s_valid = 8'h08;
    set_lane(3, 32'hD0);
    tick();
    tick();
    set_lane(3, 32'hD1);
    tick();
    check_cnt++; if (bus_if.m_src !== 3'd3) $display("[TB] FAIL mid_pre_src got %0d exp 3", bus_if.m_src); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++; if (bus_if.m_valid !== 1'b0) $display("[TB] FAIL mid_m_valid got %0b exp 0", bus_if.m_valid); else pass_cnt++;
    check_cnt++; if (bus_if.m_data !== 32'h0) $display("[TB] FAIL mid_m_data got %0h exp 0", bus_if.m_data); else pass_cnt++;
    check_cnt++; if (bus_if.m_src !== 3'd0) $display("[TB] FAIL mid_m_src got %0d exp 0", bus_if.m_src); else pass_cnt++;
    check_cnt++; if (bus_if.gnt_vec !== 8'h00) $display("[TB] FAIL mid_gnt got %0h exp 00", bus_if.gnt_vec); else pass_cnt++;
    check_cnt++; if (bus_if.s_ready !== 8'h00) $display("[TB] FAIL mid_s_ready got %0h exp 00", bus_if.s_ready); else pass_cnt++;
    check_cnt++; if (bus_if.busy !== 1'b0) $display("[TB] FAIL mid_busy got %0b exp 0", bus_if.busy); else pass_cnt++;
    bus_if.s_valid = 8'hFF;
    bus_if.s_last  = 8'hFF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_cnt++; if (bus_if.gnt_vec !== 8'h01) $display("[TB] FAIL mid_regrant got %0h exp 01", bus_if.gnt_vec); else pass_cnt++;
    tick();
    check_cnt++; if (bus_if.m_src !== 3'd0) $display("[TB] FAIL mid_regrant_src got %0d exp 0", bus_if.m_src); else pass_cnt++;
    bus_if.s_valid = 8'h00;
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus_if.s_valid = '0;
    bus_if.s_last  = '0;
    bus_if.s_data  = '0;
    bus_if.port_en = '1;
    bus_if.m_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_mask();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, check_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
